// File: rtl/rob_pkg.sv
// rob_pkg: shared constants and types for the reorder buffer / retire stage.
// Holds the entry count, id width, data width, writeback-bus field offsets,
// the exception cause encoding and the per-entry record, plus helpers that
// unpack a writeback bus into an entry and extract its id.
// Writeback bus layout (WB_INFO_W = 78):
//   {id[77:75], pc[74:43], rd_we[42], rd_addr[41:37], rd_data[36:5],
//    xcpt_valid[4], xcpt_cause[3:0]}
package rob_pkg;

    localparam int ROB_ENTRIES = 8;
    localparam int ID_W = $clog2(ROB_ENTRIES);
    localparam int DATA_WIDTH = 32;

    localparam int WB_CAUSE_LSB = 0;
    localparam int WB_XCPT_BIT = 4;
    localparam int WB_DATA_LSB = 5;
    localparam int WB_ADDR_LSB = WB_DATA_LSB + DATA_WIDTH;
    localparam int WB_WE_BIT = WB_ADDR_LSB + 5;
    localparam int WB_PC_LSB = WB_WE_BIT + 1;
    localparam int WB_ID_LSB = WB_PC_LSB + 32;
    localparam int WB_INFO_W = WB_ID_LSB + ID_W;

    typedef enum logic [3:0] {
        XCPT_NONE          = 4'h0,
        XCPT_INSN_MISALIGN = 4'h1,
        XCPT_ILLEGAL_INSN  = 4'h2,
        XCPT_BREAKPOINT    = 4'h3,
        XCPT_LOAD_FAULT    = 4'h5,
        XCPT_STORE_FAULT   = 4'h7,
        XCPT_ECALL         = 4'hB
    } xcpt_cause_e;

    typedef struct packed {
        logic                  valid;
        logic [31:0]           pc;
        logic                  rd_we;
        logic [4:0]            rd_addr;
        logic [DATA_WIDTH-1:0] rd_data;
        logic                  xcpt_valid;
        xcpt_cause_e           xcpt_cause;
    } rob_entry_t;

    function automatic rob_entry_t wb_to_entry(input logic [WB_INFO_W-1:0] info);
        rob_entry_t e;
        e.valid      = 1'b1;
        e.pc         = info[WB_PC_LSB +: 32];
        e.rd_we      = info[WB_WE_BIT];
        e.rd_addr    = info[WB_ADDR_LSB +: 5];
        e.rd_data    = info[WB_DATA_LSB +: DATA_WIDTH];
        e.xcpt_valid = info[WB_XCPT_BIT];
        e.xcpt_cause = xcpt_cause_e'(info[WB_CAUSE_LSB +: 4]);
        return e;
    endfunction

    function automatic logic [ID_W-1:0] wb_id(input logic [WB_INFO_W-1:0] info);
        return info[WB_ID_LSB +: ID_W];
    endfunction

endpackage

// File: rtl/rob_entry_array.sv
// rob_entry_array: reorder-buffer entry storage.
// Ports:
//   clock, reset              clock; synchronous active-high reset (clears all)
//   clear_all                 flush: clear every entry, drop this cycle's writes
//   head_clr, head_id         clear the head entry as it retires
//   head_entry                registered contents of entry[head_id]
//   alu_wb_*, mul_wb_*        two writeback ports; ALU wins on an id collision
//   src1_id/src2_id           forwarding lookups -> src*_hit, src*_data
// Optional: ROB_WB_BYPASS_EN lets lookups also hit on same-cycle writebacks.
module rob_entry_array
    import rob_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_all,
    input  logic                  head_clr,
    input  logic [ID_W-1:0]       head_id,
    output rob_entry_t            head_entry,
    input  logic                  alu_wb_valid,
    input  logic [WB_INFO_W-1:0]  alu_wb_info,
    input  logic                  mul_wb_valid,
    input  logic [WB_INFO_W-1:0]  mul_wb_info,
    input  logic [ID_W-1:0]       src1_id,
    input  logic [ID_W-1:0]       src2_id,
    output logic                  src1_hit,
    output logic                  src2_hit,
    output logic [DATA_WIDTH-1:0] src1_data,
    output logic [DATA_WIDTH-1:0] src2_data
);

    rob_entry_t      entry_q [ROB_ENTRIES];
    rob_entry_t      entry_d [ROB_ENTRIES];
    rob_entry_t      alu_ent, mul_ent;
    logic [ID_W-1:0] alu_id, mul_id;

    assign alu_ent    = wb_to_entry(alu_wb_info);
    assign mul_ent    = wb_to_entry(mul_wb_info);
    assign alu_id     = wb_id(alu_wb_info);
    assign mul_id     = wb_id(mul_wb_info);
    assign head_entry = entry_q[head_id];

    // ALU is applied after MUL so it wins a same-id collision; the retire
    // clear comes first so an (illegal) write to the head still lands.
    always_comb begin
        entry_d = entry_q;
        if (head_clr) entry_d[head_id].valid = 1'b0;
        if (mul_wb_valid) entry_d[mul_id] = mul_ent;
        if (alu_wb_valid) entry_d[alu_id] = alu_ent;
        if (clear_all) entry_d = '{default: '0};
    end

    always_ff @(posedge clock) begin
        if (reset) entry_q <= '{default: '0};
        else entry_q <= entry_d;
    end

    // Returns {hit, data}; port data takes priority over stored data when the
    // same-cycle bypass is built in.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [ID_W-1:0] id);
        logic [DATA_WIDTH:0] r;
        r = entry_q[id].valid ? {1'b1, entry_q[id].rd_data} : '0;
`ifdef ROB_WB_BYPASS_EN
        if (mul_wb_valid && !mul_ent.xcpt_valid && mul_id == id) r = {1'b1, mul_ent.rd_data};
        if (alu_wb_valid && !alu_ent.xcpt_valid && alu_id == id) r = {1'b1, alu_ent.rd_data};
`endif
        return r;
    endfunction

    always_comb begin
        {src1_hit, src1_data} = lookup(src1_id);
        {src2_hit, src2_data} = lookup(src2_id);
    end

    always_ff @(posedge clock) begin
        if (!reset && !clear_all) begin
            assert (!(alu_wb_valid && mul_wb_valid && alu_id == mul_id));
            assert (!(alu_wb_valid && entry_q[alu_id].valid));
            assert (!(mul_wb_valid && entry_q[mul_id].valid));
        end
    end

endmodule

// File: rtl/rob_retire_unit.sv
// rob_retire_unit: in-order reorder buffer and retire stage.
// Sizes come from rob_pkg (ROB_ENTRIES = 8, DATA_WIDTH = 32).
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   alloc_valid, rob_full        decode allocation / occupancy full
//   alu_wb_*, mul_wb_*           writeback ports (layout in rob_pkg)
//   src1/src2 id/hit/data        combinational forwarding lookups
//   retire_valid, rf_wr_*        registered retire and register-file write
//   xcpt_valid/pc/cause          registered exception report
//   flush_rob                    registered one-cycle pipeline flush
// Optional: ROB_WB_BYPASS_EN (forwarding from same-cycle writebacks).
module rob_retire_unit
    import rob_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alloc_valid,
    output logic                  rob_full,
    input  logic                  alu_wb_valid,
    input  logic [WB_INFO_W-1:0]  alu_wb_info,
    input  logic                  mul_wb_valid,
    input  logic [WB_INFO_W-1:0]  mul_wb_info,
    input  logic [ID_W-1:0]       src1_id,
    input  logic [ID_W-1:0]       src2_id,
    output logic                  src1_hit,
    output logic                  src2_hit,
    output logic [DATA_WIDTH-1:0] src1_data,
    output logic [DATA_WIDTH-1:0] src2_data,
    output logic                  retire_valid,
    output logic                  rf_wr_en,
    output logic [4:0]            rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  xcpt_valid,
    output logic [31:0]           xcpt_pc,
    output logic [3:0]            xcpt_cause,
    output logic                  flush_rob
);

    localparam int CNT_W = ID_W + 1;

    rob_entry_t            head_entry;
    logic                  retire, flush;
    logic [ID_W-1:0]       head_q, head_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  retire_valid_q, retire_valid_d;
    logic                  rf_wr_en_q, rf_wr_en_d;
    logic [4:0]            rf_wr_addr_q, rf_wr_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
    logic                  xcpt_valid_q, xcpt_valid_d;
    logic [31:0]           xcpt_pc_q, xcpt_pc_d;
    logic [3:0]            xcpt_cause_q, xcpt_cause_d;
    logic                  flush_rob_q, flush_rob_d;

    rob_entry_array u_entries (
        .clock        (clock),
        .reset        (reset),
        .clear_all    (flush),
        .head_clr     (retire),
        .head_id      (head_q),
        .head_entry   (head_entry),
        .alu_wb_valid (alu_wb_valid),
        .alu_wb_info  (alu_wb_info),
        .mul_wb_valid (mul_wb_valid),
        .mul_wb_info  (mul_wb_info),
        .src1_id      (src1_id),
        .src2_id      (src2_id),
        .src1_hit     (src1_hit),
        .src2_hit     (src2_hit),
        .src1_data    (src1_data),
        .src2_data    (src2_data)
    );

    // Retire is decided purely from registered state: the head entry is valid.
    assign retire   = head_entry.valid;
    assign flush    = retire && head_entry.xcpt_valid;
    assign rob_full = count_q == CNT_W'(ROB_ENTRIES);

    always_comb begin
        retire_valid_d = retire;
        rf_wr_en_d     = retire && head_entry.rd_we && !head_entry.xcpt_valid;
        rf_wr_addr_d   = retire ? head_entry.rd_addr : rf_wr_addr_q;
        rf_wr_data_d   = retire ? head_entry.rd_data : rf_wr_data_q;
        xcpt_pc_d      = retire ? head_entry.pc : xcpt_pc_q;
        xcpt_cause_d   = retire ? head_entry.xcpt_cause : xcpt_cause_q;
        xcpt_valid_d   = flush;
        flush_rob_d    = flush;
        // A flush restarts ids at 0 and drops this cycle's allocation.
        head_d  = flush ? '0 : head_q + ID_W'(retire);
        count_d = flush ? '0 : count_q + CNT_W'(alloc_valid && !rob_full) - CNT_W'(retire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q         <= '0;
            count_q        <= '0;
            retire_valid_q <= 1'b0;
            rf_wr_en_q     <= 1'b0;
            rf_wr_addr_q   <= '0;
            rf_wr_data_q   <= '0;
            xcpt_valid_q   <= 1'b0;
            xcpt_pc_q      <= '0;
            xcpt_cause_q   <= '0;
            flush_rob_q    <= 1'b0;
        end else begin
            head_q         <= head_d;
            count_q        <= count_d;
            retire_valid_q <= retire_valid_d;
            rf_wr_en_q     <= rf_wr_en_d;
            rf_wr_addr_q   <= rf_wr_addr_d;
            rf_wr_data_q   <= rf_wr_data_d;
            xcpt_valid_q   <= xcpt_valid_d;
            xcpt_pc_q      <= xcpt_pc_d;
            xcpt_cause_q   <= xcpt_cause_d;
            flush_rob_q    <= flush_rob_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) assert (!(alloc_valid && rob_full));
    end

    assign retire_valid = retire_valid_q;
    assign rf_wr_en     = rf_wr_en_q;
    assign rf_wr_addr   = rf_wr_addr_q;
    assign rf_wr_data   = rf_wr_data_q;
    assign xcpt_valid   = xcpt_valid_q;
    assign xcpt_pc      = xcpt_pc_q;
    assign xcpt_cause   = xcpt_cause_q;
    assign flush_rob    = flush_rob_q;

endmodule
